// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine holding the HI/LO registers.
module mult_div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
   state_t state, next;
   logic is_div, neg_q, neg_r, dbz;
   logic [DATA_W-1:0] a, b, raw_a, quo, rem;
   logic [CNT_W-1:0] cnt;
   logic [2*DATA_W-1:0] acc, prod;
   logic [DATA_W:0] add_sum, rem_sh, diff;
   logic sgn;
   assign busy = state != IDLE;
   assign sgn = ~op[0];
   always_comb begin
      next = state;
      next = (state == IDLE && start) ? CALC :
             (state == CALC && cnt == LAST) ? FINISH :
             (state == FINISH) ? IDLE : state;
   end
   // Multiply consumes multiplier bits LSB-first; divide consumes dividend bits MSB-first.
   always_comb begin
      add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, b[cnt] ? a : '0};
      rem_sh  = {acc[2*DATA_W-1:DATA_W], a[LAST - cnt]};
      diff    = rem_sh - {1'b0, b};
      prod    = neg_q ? -acc : acc;
      quo     = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
      rem     = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         done   <= 1'b0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dbz    <= 1'b0;
         a      <= '0;
         b      <= '0;
         raw_a  <= '0;
         cnt    <= '0;
         acc    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= next;
         done  <= state == FINISH;
         if (state == IDLE) begin
            if (start) begin
               is_div <= op[1];
               a      <= (sgn && src_a[DATA_W-1]) ? -src_a : src_a;
               b      <= (sgn && src_b[DATA_W-1]) ? -src_b : src_b;
               neg_q  <= sgn & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
               neg_r  <= sgn & src_a[DATA_W-1];
               dbz    <= src_b == '0;
               raw_a  <= src_a;
               cnt    <= '0;
               acc    <= '0;
            end else begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
            end
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            acc <= is_div ? {diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0], acc[DATA_W-2:0], ~diff[DATA_W]}
                          : {add_sum, acc[DATA_W-1:1]};
         end else begin
            hi <= !is_div ? prod[2*DATA_W-1:DATA_W] : dbz ? raw_a : rem;
            lo <= !is_div ? prod[DATA_W-1:0] : dbz ? '1 : quo;
         end
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0] op = 2'd0;
   logic [31:0] src_a = '0, src_b = '0, wdata = '0;
   logic busy, done;
   logic [31:0] hi, lo;
   int n_chk = 0, n_fail = 0, lat, bc, n_d;
   logic [63:0] sb[$];

   mult_div_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
                      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo));

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] sx, sy;
      sx = x;
      sy = y;
      case (o)
         2'd0: return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
         2'd1: return {32'h0, x} * {32'h0, y};
         2'd2: if (y == 32'h0) return {x, 32'hFFFFFFFF};
               else if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
               else return {32'(sx % sy), 32'(sx / sy)};
         default: return (y == 32'h0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns one falling edge after the start edge.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push = 1'b1);
      start = 1'b1;
      op = o;
      src_a = x;
      src_b = y;
      if (push) sb.push_back(model(o, x, y));
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom);
      src_a = $urandom;
      src_b = $urandom;
   endtask

   task automatic wait_done(input string tag, output int l, output int b);
      l = 0;
      b = 0;
      while (done !== 1'b1 && l < 50) begin
         b += int'(busy);
         @(negedge clk);
         l++;
      end
      check({tag, " done"}, 64'(done), 64'd1);
      if (done === 1'b1 && sb.size() > 0) begin
         check({tag, " hi/lo"}, {hi, lo}, sb.pop_front());
         check({tag, " busy"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset busy/done", {62'h0, busy, done}, 64'h0);
      check("reset hi/lo", {hi, lo}, 64'h0);
      rst = 1'b0;
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hA5A50001;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mthi+mtlo", {hi, lo}, {2{32'hA5A50001}});
      lo_we = 1'b1;
      wdata = 32'h2;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo only", {hi, lo}, {32'hA5A50001, 32'h2});

      do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done("multu max", lat, bc);
      check("multu latency", 64'(lat), 64'd33);
      check("multu value", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});

      hi_we = 1'b1;
      wdata = 32'h1111;
      do_op(2'd0, 32'hFFFFFFFD, 32'd5);
      check("start beats mthi", {32'h0, hi}, {32'h0, 32'hFFFFFFFE});
      check("done one cycle", 64'(done), 64'd0);
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi while busy", {32'h0, hi}, {32'h0, 32'hFFFFFFFE});
      bc = 0;
      wait_done("mult -3x5", lat, n_d);
      check("mult busy cycles", 64'(n_d + 1), 64'd33);
      check("mult value", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});

      do_op(2'd2, 32'hFFFFFFF9, 32'd2);
      wait_done("div -7/2", lat, bc);
      check("div -7/2 value", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
      do_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div overflow", lat, bc);
      check("div overflow value", {hi, lo}, {32'h0, 32'h80000000});
      do_op(2'd3, 32'd100, 32'd0);
      wait_done("divu by zero", lat, bc);
      check("divu by zero latency", 64'(lat), 64'd33);
      do_op(2'd2, 32'hFFFFFFFB, 32'd0);
      wait_done("div by zero", lat, bc);

      do_op(2'd1, 32'd7, 32'd9, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst busy/done", {62'h0, busy, done}, 64'h0);
      check("async rst hi/lo", {hi, lo}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      n_d = 0;
      repeat (40) begin
         @(negedge clk);
         n_d += int'(done);
      end
      check("no done after rst", 64'(n_d), 64'd0);
      lo_we = 1'b1;
      wdata = 32'h1234;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo after rst", {hi, lo}, {32'h0, 32'h1234});

      do_op(2'd3, 32'd50, 32'd7);
      repeat (3) @(negedge clk);
      start = 1'b1;
      op = 2'd3;
      src_a = 32'd1;
      src_b = 32'd1;
      hi_we = 1'b1;
      wdata = 32'hDEAD;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      check("busy mthi ignored", {32'h0, hi}, 64'h0);
      wait_done("divu 50/7", lat, bc);
      check("divu 50/7 value", {hi, lo}, {32'd1, 32'd7});
      n_d = 0;
      repeat (40) begin
         @(negedge clk);
         n_d += int'(done);
      end
      check("single done", 64'(n_d), 64'd0);

      for (int i = 0; i < 8; i++) begin
         do_op(2'(i), $urandom, (i > 3) ? 32'($urandom_range(1, 300)) : $urandom);
         wait_done("random op", lat, bc);
         check("random latency", 64'(lat), 64'd33);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
